// File: rtl/spram_arbiter_pkg.sv
// Shared helpers for the spram arbiter slice.
package spram_arbiter_pkg;

  // Index width for a pointer over n requesters; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spram_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from last_grant+1,
// pointer moves to the granted index at each advancing edge.
module rr_arbiter
  import spram_arbiter_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned PW = ptr_width(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  logic [PW-1:0] last_grant;
  logic [PW-1:0] cand;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = PW'((32'(last_grant) + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Reset points at the last requester so requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= PW'(N - 1);
    end else if (advance && found) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/spram_arbiter.sv
// Shares one single-port RAM (1-cycle registered read) among NUM_REQ requesters
// with round-robin arbitration and one-hot tagged read responses.
module spram_arbiter
  import spram_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned AWIDTH    = 10,
  parameter int unsigned NUM_WORDS = 1024,
  parameter int unsigned DWIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_wren,
  input  logic [NUM_REQ*AWIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DWIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DWIDTH-1:0]         rsp_data,
  output logic [AWIDTH-1:0]         ram_address,
  output logic                      ram_wren,
  output logic [DWIDTH-1:0]         ram_data,
  input  logic [DWIDTH-1:0]         ram_out
);

  localparam int unsigned PW = ptr_width(NUM_REQ);

  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      grant_idx;
  logic [NUM_REQ-1:0] pending;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .advance   (!reset),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grant and RAM drive are gated by reset so nothing is written while held.
  always_comb begin
    req_ready   = '0;
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    if (!reset && (|grant)) begin
      req_ready   = grant;
      ram_address = req_addr[32'(grant_idx)*AWIDTH +: AWIDTH];
      ram_data    = req_data[32'(grant_idx)*DWIDTH +: DWIDTH];
      ram_wren    = req_wren[grant_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= req_ready & ~req_wren;
    end
  end

  assign rsp_valid = reset ? '0 : pending;
  assign rsp_data  = ram_out;

  a_addr_in_range: assert property (@(posedge clk) disable iff (reset)
    !ram_wren || (32'(ram_address) < NUM_WORDS));

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: spram stand-in plus a behavioural arbiter/memory model.
module tb_spram_arbiter;
  localparam int N = 4, AW = 10, DW = 32, WORDS = 1024;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_wren, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   rsp_data, ram_data, ram_out;
  logic [AW-1:0]   ram_address;
  logic            ram_wren;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] sp_mem [WORDS];
  logic [DW-1:0] ref_mem [WORDS];

  int            m_last = N - 1;
  int            m_pend = -1;
  logic [DW-1:0] m_pend_data;
  int            exp_g;
  logic [N-1:0]  exp_ready, exp_rsp_valid;
  logic          exp_wren;
  logic [DW-1:0] exp_rsp_data;

  spram_arbiter #(.NUM_REQ(N), .AWIDTH(AW), .NUM_WORDS(WORDS), .DWIDTH(DW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_wren(req_wren),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .ram_address(ram_address),
    .ram_wren(ram_wren), .ram_data(ram_data), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) sp_mem[ram_address] <= ram_data;
    ram_out <= sp_mem[ram_address];
  end

  function automatic logic [N*AW-1:0] pa(input int i, input int addr);
    logic [N*AW-1:0] r;
    r = '0;
    r[i*AW +: AW] = AW'(addr);
    return r;
  endfunction

  function automatic logic [N*DW-1:0] pd(input int i, input logic [DW-1:0] data);
    logic [N*DW-1:0] r;
    r = '0;
    r[i*DW +: DW] = data;
    return r;
  endfunction

  task automatic apply(input logic rst, input logic [N-1:0] v, input logic [N-1:0] w,
                       input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
    reset = rst; req_valid = v; req_wren = w; req_addr = a; req_data = d;
    #1;
    exp_g = -1;
    if (!rst)
      for (int k = 1; k <= N; k++)
        if (exp_g < 0 && v[(m_last + k) % N]) exp_g = (m_last + k) % N;
    exp_ready     = (exp_g >= 0) ? (N'(1) << exp_g) : '0;
    exp_wren      = (exp_g >= 0) ? w[exp_g] : 1'b0;
    exp_rsp_valid = (rst || m_pend < 0) ? '0 : (N'(1) << m_pend);
    exp_rsp_data  = m_pend_data;
  endtask

  task automatic tick();
    if (reset) begin
      m_last = N - 1;
      m_pend = -1;
    end else begin
      m_pend = -1;
      if (exp_g >= 0) begin
        m_last = exp_g;
        if (req_wren[exp_g]) ref_mem[req_addr[exp_g*AW +: AW]] = req_data[exp_g*DW +: DW];
        else begin
          m_pend = exp_g;
          m_pend_data = ref_mem[req_addr[exp_g*AW +: AW]];
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 6; c++) begin
      if (c < 3) apply(1'b1, '1, '1, '0, '1);
      else       apply(1'b0, '0, '0, '0, '0);
      checks++;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL reset_ready c%0d: got %b want %b", c, req_ready, exp_ready); end
      checks++;
      if (rsp_valid !== exp_rsp_valid) begin errors++; $display("FAIL reset_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_rsp_valid); end
      checks++;
      if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_wren c%0d: got %b want 0", c, ram_wren); end
      tick();
    end
  endtask

  task automatic test_write_read();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: apply(1'b0, 4'b0010, 4'b0010, pa(1, 'h005), pd(1, 32'hDEADBEEF));
        1: apply(1'b0, 4'b0010, 4'b0000, pa(1, 'h005), '0);
        default: apply(1'b0, '0, '0, '0, '0);
      endcase
      checks++;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL wr_rd_ready c%0d: got %b want %b", c, req_ready, exp_ready); end
      checks++;
      if (rsp_valid !== exp_rsp_valid) begin errors++; $display("FAIL wr_rd_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_rsp_valid); end
      if (c == 2) begin
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_data !== 32'hDEADBEEF) begin
          errors++; $display("FAIL wr_rd_data: got %b/%h want 0010/deadbeef", rsp_valid, rsp_data);
        end
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [N*AW-1:0] a_all;
    a_all = '0;
    for (int i = 0; i < N; i++) a_all |= pa(i, 'h10 + i);
    for (int c = 0; c < N + 9; c++) begin
      if (c < N)          apply(1'b0, N'(1) << c, N'(1) << c, pa(c, 'h10 + c), pd(c, DW'('h100 + c)));
      else if (c < N + 8) apply(1'b0, '1, '0, a_all, '0);
      else                apply(1'b0, '0, '0, '0, '0);
      checks++;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL rr_ready c%0d: got %b want %b", c, req_ready, exp_ready); end
      checks++;
      if (rsp_valid !== exp_rsp_valid) begin errors++; $display("FAIL rr_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_rsp_valid); end
      if (c >= N && c < N + 8) begin
        checks++;
        if (req_ready !== (N'(1) << ((c - N) % N))) begin
          errors++; $display("FAIL rr_order c%0d: got %b want index %0d", c, req_ready, (c - N) % N);
        end
      end
      if (c > N) begin
        checks++;
        if (rsp_data !== DW'('h100 + (c - N - 1) % N)) begin
          errors++; $display("FAIL rr_data c%0d: got %h want %h", c, rsp_data, 'h100 + (c - N - 1) % N);
        end
      end
      tick();
    end
  endtask

  task automatic test_raw();
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: apply(1'b0, 4'b0100, 4'b0100, pa(2, 'h3FF), pd(2, 32'h12345678));
        1: apply(1'b0, 4'b0001, 4'b0000, pa(0, 'h3FF), '0);
        default: apply(1'b0, '0, '0, '0, '0);
      endcase
      checks++;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL raw_ready c%0d: got %b want %b", c, req_ready, exp_ready); end
      if (c == 2) begin
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 32'h12345678) begin
          errors++; $display("FAIL raw_data: got %b/%h want 0001/12345678", rsp_valid, rsp_data);
        end
      end
      tick();
    end
  endtask

  task automatic test_fairness();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: apply(1'b0, 4'b1000, '0, pa(3, 'h10), '0);
        1, 2: apply(1'b0, 4'b1001, '0, pa(0, 'h11) | pa(3, 'h12), '0);
        default: apply(1'b0, '0, '0, '0, '0);
      endcase
      checks++;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL fair_ready c%0d: got %b want %b", c, req_ready, exp_ready); end
      checks++;
      if (rsp_valid !== exp_rsp_valid) begin errors++; $display("FAIL fair_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_rsp_valid); end
      if (c == 1 || c == 2) begin
        checks++;
        if (req_ready !== ((c == 1) ? 4'b0001 : 4'b1000)) begin
          errors++; $display("FAIL fair_order c%0d: got %b", c, req_ready);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_read();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: apply(1'b0, 4'b0010, '0, pa(1, 'h11), '0);
        1: apply(1'b1, '1, '0, '0, '0);
        2: apply(1'b0, '1, '0, '0, '0);
        default: apply(1'b0, '0, '0, '0, '0);
      endcase
      checks++;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL rst_mid_ready c%0d: got %b want %b", c, req_ready, exp_ready); end
      checks++;
      if (rsp_valid !== exp_rsp_valid) begin errors++; $display("FAIL rst_mid_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_rsp_valid); end
      if (c == 1 || c == 2) begin
        checks++;
        if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_mid_lost c%0d: got %b want 0000", c, rsp_valid); end
      end
      if (c == 2) begin
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_mid_first: got %b want 0001", req_ready); end
      end
      tick();
    end
  endtask

  task automatic test_single_holder();
    for (int c = 0; c < 5; c++) begin
      apply(1'b0, 4'b0100, '0, pa(2, 'h10 + c % 4), '0);
      checks++;
      if (req_ready !== 4'b0100) begin errors++; $display("FAIL hold_ready c%0d: got %b want 0100", c, req_ready); end
      checks++;
      if (rsp_valid !== exp_rsp_valid) begin errors++; $display("FAIL hold_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_rsp_valid); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [N-1:0]    v, w;
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    logic            r;
    for (int c = 0; c < 416; c++) begin
      if (c < 16) begin
        r = 1'b0; v = N'(1) << (c % N); w = v;
        a = pa(c % N, 'h20 + c); d = pd(c % N, $urandom);
      end else begin
        r = ($urandom_range(0, 39) == 0);
        v = N'($urandom); w = N'($urandom);
        a = '0; d = '0;
        for (int i = 0; i < N; i++) begin
          a |= pa(i, 'h20 + $urandom_range(0, 15));
          d |= pd(i, $urandom);
        end
      end
      apply(r, v, w, a, d);
      checks++;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready c%0d: got %b want %b", c, req_ready, exp_ready); end
      checks++;
      if (ram_wren !== exp_wren) begin errors++; $display("FAIL rand_wren c%0d: got %b want %b", c, ram_wren, exp_wren); end
      checks++;
      if (rsp_valid !== exp_rsp_valid) begin errors++; $display("FAIL rand_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_rsp_valid); end
      if (exp_g >= 0) begin
        checks++;
        if (ram_address !== a[exp_g*AW +: AW]) begin errors++; $display("FAIL rand_addr c%0d: got %h want %h", c, ram_address, a[exp_g*AW +: AW]); end
      end
      if (exp_rsp_valid != '0) begin
        checks++;
        if (rsp_data !== exp_rsp_data) begin errors++; $display("FAIL rand_data c%0d: got %h want %h", c, rsp_data, exp_rsp_data); end
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_wren = '0; req_addr = '0; req_data = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_round_robin();
    test_raw();
    test_fairness();
    test_reset_mid_read();
    test_single_holder();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Shares one spram instance (single-port, 1-cycle registered read) between NUM_REQ requesters using round-robin arbitration.
- Each requester sees a valid/ready request channel and a one-hot response strobe.
- Sits between compute tiles (e.g. weight fetch, activation writeback) and a shared on-chip buffer.
- Drives spram address/wren/data and returns its out data, tagged to the requester that issued the read.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- AWIDTH, 10, spram address width.
- NUM_WORDS, 1024, spram depth, passed through to the memory.
- DWIDTH, 32, data width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_wren  input  NUM_REQ  per-requester write (1) / read (0).
- req_addr  input  NUM_REQ*AWIDTH  flattened addresses; requester i occupies [i*AWIDTH +: AWIDTH].
- req_data  input  NUM_REQ*DWIDTH  flattened write data, same packing.
- req_ready  output  NUM_REQ  one-hot grant; transfer occurs when valid&ready.
- rsp_valid  output  NUM_REQ  one-hot; read data for requester i is valid this cycle.
- rsp_data  output  DWIDTH  read data, shared by all requesters.
- ram_address  output  AWIDTH  to spram address.
- ram_wren  output  1  to spram wren.
- ram_data  output  DWIDTH  to spram data.
- ram_out  input  DWIDTH  from spram out.

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous, active-high.
- Reset values:
  - rsp_valid=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has top priority first.
  - Pending-read register cleared.
  - While reset=1: req_ready=0 and ram_wren=0 (combinationally gated).
- Arbitration (combinational, every cycle):
  - Search req_valid starting at index last_grant+1, wrapping modulo NUM_REQ.
  - The first asserted requester g is granted: req_ready = one-hot(g).
  - At most one grant per cycle; zero grants when no req_valid.
  - req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
- Pointer update: at each clock edge with a grant, last_grant <= g. Otherwise unchanged.
- Memory drive (combinational from the grant):
  - ram_address = req_addr[g], ram_data = req_data[g], ram_wren = req_wren[g].
  - With no grant: ram_wren=0, ram_address=0, ram_data=0. This causes a harmless idle read.
- Write: committed at the edge of the grant cycle. No response. rsp_valid is not asserted for writes.
- Read:
  - Grant in cycle N -> rsp_valid[g]=1 in cycle N+1 for exactly one cycle.
  - rsp_data = ram_out (pass-through) in cycle N+1.
  - Implemented with a registered one-hot pending vector (read-accepted & grant).
  - Latency is fixed at 1 cycle. There is no response backpressure; requesters must sink rsp in that cycle.
- Throughput:
  - One access per cycle. Back-to-back reads from different requesters produce back-to-back rsp_valid with differing one-hot values.
  - A single requester holding valid gets every cycle when no one else requests.
- Fairness: with all NUM_REQ requesting continuously, each is granted exactly once per NUM_REQ cycles. Maximum wait is NUM_REQ-1 cycles.
- Read-after-write to the same address from different requesters in consecutive cycles returns the new data (write at edge N, read at edge N+1).
- rsp_data outside rsp_valid cycles is don't-care. It holds the last spram read output.
- Reset mid-operation:
  - A read granted in the cycle before reset asserts: its rsp_valid is suppressed, because the pending register is cleared at the reset edge. The response is lost, by design.
  - A write presented while reset=1 is not performed.
- Address range: the address is passed unchecked; software keeps addresses < NUM_WORDS.

Decomposition:
- Shared package: none required. Widths are parameters. An optional localparam for clog2(NUM_REQ) pointer width stays local.
- One sub-module: rr_arbiter (parameter N).
  - Inputs: clk, reset, req[N], advance.
  - Outputs: grant one-hot[N], grant_idx.
  - Holds last_grant. spram_arbiter adds the mux, the pending-read register and response steering.

Test Plan:
- Reset, then idle:
  - Required: req_ready=0, rsp_valid=0, ram_wren=0 every cycle, including during reset with all req_valid=1.
- Single write then read:
  - Stimulus: req1 writes addr 0x005 data 0xDEADBEEF in cycle 2; req1 reads 0x005 in cycle 3.
  - Required: rsp_valid=4'b0010 with rsp_data=0xDEADBEEF in cycle 4.
- All four requesters hold read requests for 8 cycles (addresses 0x10+i, preloaded with value 0x100+i):
  - Grants follow 0,1,2,3,0,1,2,3.
  - Each rsp_valid one cycle later carries rsp_data=0x100+i.
- Cross-requester RAW:
  - Stimulus: req2 writes 0x3FF with 0x12345678 in cycle N; req0 reads 0x3FF in cycle N+1.
  - Required: req0 gets 0x12345678 in cycle N+2.
- Fairness after priority:
  - Stimulus: req3 is granted, then req0 and req3 both valid.
  - Required: req0 is granted next; req3 waits 1 cycle.
- Reset mid-read:
  - Stimulus: req1 read granted in cycle N; reset=1 in cycle N+1.
  - Required: rsp_valid stays 0. After release, req0 wins first.
